// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch prefetch stage.
package if_pkg;

    localparam int unsigned IF_ADDR_W   = 32;
    localparam int unsigned IF_DATA_W   = 32;
    localparam int unsigned IF_DEPTH    = 4;
    localparam int unsigned IF_PC_STEP  = 4;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    // One queue entry at default widths: the PC to hand to decode plus its instruction.
    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_DATA_W-1:0] instr;
    } if_entry_t;

endpackage

// File: rtl/if_stage_prefetch_if.sv
// Instruction-memory bus: fetch stage is master (drives address), memory is slave.
interface if_stage_prefetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [DATA_W-1:0] imem_rdata;

    modport master (output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_fifo.sv
// Prefetch queue: circular buffer with push/pop/flush and occupancy count.
// Push while full is legal only together with a pop (caller guarantees this).
module if_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CntW-1:0]  count_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q, count_d;

    // Occupancy next-state: +1 push only, -1 pop only, unchanged otherwise.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and count; flush and reset both empty the queue in one edge.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PtrW'(1);
            if (pop_i)  rptr_q <= rptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage with a prefetch queue between imem and decode.
// Optional macro IF_PERF_CNT_EN adds flush_cnt / stall_cnt performance counters.
module if_stage_prefetch
    import if_pkg::*;
#(
    parameter int unsigned       ADDR_W   = IF_ADDR_W,
    parameter int unsigned       DATA_W   = IF_DATA_W,
    parameter int unsigned       DEPTH    = IF_DEPTH,
    parameter int unsigned       PC_STEP  = IF_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  Branch_token,
    input  logic [ADDR_W-1:0]     BranchAddr,
    if_stage_prefetch_if.master   imem,
    output logic                  out_valid,
    output logic [ADDR_W-1:0]     PC,
    output logic [DATA_W-1:0]     Instruction,
    output logic [$clog2(DEPTH):0] count
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]           flush_cnt,
    output logic [31:0]           stall_cnt
`endif
);
    localparam int unsigned EntryW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] next_pc;
    logic              push, pop, full, empty;
    logic [EntryW-1:0] head;

    assign next_pc        = fetch_pc_q + ADDR_W'(PC_STEP);
    assign imem.imem_addr = fetch_pc_q;

    assign out_valid = ~empty;
    assign pop       = out_valid & ~freeze & ~Branch_token;
    // Full queue still accepts a fetch when the head leaves in the same cycle.
    assign push      = imem.imem_ready & ~Branch_token & (~full | pop);

    // Fetch PC next-state: redirect beats sequential advance.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (Branch_token) begin
            fetch_pc_d = BranchAddr;
        end else if (push) begin
            fetch_pc_d = next_pc;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (rst) fetch_pc_q <= RESET_PC;
        else     fetch_pc_q <= fetch_pc_d;
    end

    if_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (Branch_token),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({next_pc, imem.imem_rdata}),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign PC          = head[EntryW-1:DATA_W];
    assign Instruction = head[DATA_W-1:0];

`ifdef IF_PERF_CNT_EN
    logic [31:0] flush_cnt_q, stall_cnt_q;

    // Flush cycles and cycles where decode holds a valid head.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (Branch_token)       flush_cnt_q <= flush_cnt_q + 32'd1;
            if (out_valid && freeze) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign flush_cnt = flush_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Directed bench for if_stage_prefetch; memory returns addr ^ 0xDEAD0000.
// A second instance with RESET_PC = 0xFFFFFFFC covers PC wrap-around.
module tb_if_stage_prefetch;
    logic        clk = 1'b0;
    logic        rst, freeze, branch;
    logic [31:0] baddr;
    logic        out_valid, out_valid2;
    logic [31:0] pc, instr, pc2, instr2;
    logic [2:0]  count, count2;
    logic        zero = 1'b0;
    logic [31:0] zero_addr = 32'h0;
`ifdef IF_PERF_CNT_EN
    logic [31:0] flush_cnt, stall_cnt, flush_cnt2, stall_cnt2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_stage_prefetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    if_stage_prefetch_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    assign bus.imem_rdata  = bus.imem_addr ^ 32'hDEAD_0000;
    assign bus2.imem_rdata = bus2.imem_addr ^ 32'hDEAD_0000;
    assign bus2.imem_ready = 1'b1;

    if_stage_prefetch dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .Branch_token (branch),
        .BranchAddr   (baddr),
        .imem         (bus),
        .out_valid    (out_valid),
        .PC           (pc),
        .Instruction  (instr),
        .count        (count)
`ifdef IF_PERF_CNT_EN
        ,
        .flush_cnt    (flush_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    if_stage_prefetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .freeze       (zero),
        .Branch_token (zero),
        .BranchAddr   (zero_addr),
        .imem         (bus2),
        .out_valid    (out_valid2),
        .PC           (pc2),
        .Instruction  (instr2),
        .count        (count2)
`ifdef IF_PERF_CNT_EN
        ,
        .flush_cnt    (flush_cnt2),
        .stall_cnt    (stall_cnt2)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch = 1'b0; baddr = '0;
        bus.imem_ready = 1'b1;
        tick(2);
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_addr", 64'(bus.imem_addr), 64'h0);
        check("rst_addr_wrapdut", 64'(bus2.imem_addr), 64'hFFFF_FFFC);

        // Streaming: one-cycle latency, PC 4, 8, 12 with occupancy 1.
        rst = 1'b0;
        tick();
        check("run1_valid", 64'(out_valid), 64'd1);
        check("run1_pc", 64'(pc), 64'h4);
        check("run1_instr", 64'(instr), 64'hDEAD_0000);
        check("run1_count", 64'(count), 64'd1);
        check("wrap1_pc", 64'(pc2), 64'h0);
        check("wrap1_instr", 64'(instr2), 64'h2152_FFFC);
        tick();
        check("run2_pc", 64'(pc), 64'h8);
        check("run2_count", 64'(count), 64'd1);
        check("wrap2_pc", 64'(pc2), 64'h4);
        tick();
        check("run3_pc", 64'(pc), 64'hC);
        check("run3_instr", 64'(instr), 64'hDEAD_0008);
        check("run3_count", 64'(count), 64'd1);

        // Freeze from reset release: fills to 4, fetch address parks at 16.
        rst = 1'b1;
        tick();
        rst = 1'b0; freeze = 1'b1;
        tick(6);
        check("frz_count", 64'(count), 64'd4);
        check("frz_addr", 64'(bus.imem_addr), 64'h10);
        check("frz_pc", 64'(pc), 64'h4);
        check("frz_instr", 64'(instr), 64'hDEAD_0000);
        freeze = 1'b0;
        tick();
        check("drain_pc8", 64'(pc), 64'h8);
        check("drain_count", 64'(count), 64'd4);
        tick();
        check("drain_pc12", 64'(pc), 64'hC);
        tick();
        check("drain_pc16", 64'(pc), 64'h10);

        // Branch while three entries are queued.
        rst = 1'b1;
        tick();
        rst = 1'b0; freeze = 1'b1;
        tick(3);
        check("pre_br_count", 64'(count), 64'd3);
        branch = 1'b1; baddr = 32'h100;
        tick();
        check("br_count", 64'(count), 64'd0);
        check("br_valid", 64'(out_valid), 64'd0);
        check("br_addr", 64'(bus.imem_addr), 64'h100);
        branch = 1'b0; freeze = 1'b0;
        tick();
        check("br_head_valid", 64'(out_valid), 64'd1);
        check("br_head_pc", 64'(pc), 64'h104);
        check("br_head_instr", 64'(instr), 64'hDEAD_0100);

        // Branch and freeze together on a full queue: flush wins.
        freeze = 1'b1;
        tick(4);
        check("full_count", 64'(count), 64'd4);
        branch = 1'b1; baddr = 32'h200;
        tick();
        check("brfrz_count", 64'(count), 64'd0);
        check("brfrz_addr", 64'(bus.imem_addr), 64'h200);

        // imem not ready: no push, address holds; pop still proceeds.
        branch = 1'b0; freeze = 1'b0; bus.imem_ready = 1'b0;
        tick();
        check("nrdy_count", 64'(count), 64'd0);
        check("nrdy_addr", 64'(bus.imem_addr), 64'h200);
        bus.imem_ready = 1'b1;
        tick();
        check("rdy_pc", 64'(pc), 64'h204);
        check("rdy_count", 64'(count), 64'd1);
        bus.imem_ready = 1'b0;
        tick();
        check("nrdy_pop_count", 64'(count), 64'd0);
        check("nrdy_pop_valid", 64'(out_valid), 64'd0);

        // Reset mid-operation discards entries and overrides a branch.
        bus.imem_ready = 1'b1; freeze = 1'b1;
        tick(2);
        check("pre_rst_count", 64'(count), 64'd2);
        rst = 1'b1;
        tick();
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_addr", 64'(bus.imem_addr), 64'h0);
        branch = 1'b1; baddr = 32'h300;
        tick();
        check("rst_over_br_addr", 64'(bus.imem_addr), 64'h0);
        branch = 1'b0; freeze = 1'b0;

`ifdef IF_PERF_CNT_EN
        // 5 frozen-valid cycles, then 3 single-cycle branch pulses.
        rst = 1'b0;
        tick();
        freeze = 1'b1;
        tick(5);
        freeze = 1'b0;
        for (int k = 0; k < 3; k++) begin
            branch = 1'b1;
            tick();
            branch = 1'b0;
            tick();
        end
        check("flush_cnt", 64'(flush_cnt), 64'd3);
        check("stall_cnt", 64'(stall_cnt), 64'd5);
        rst = 1'b1;
        tick();
        check("flush_cnt_rst", 64'(flush_cnt), 64'd0);
        check("stall_cnt_rst", 64'(stall_cnt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage_prefetch.md
IF_STAGE_PREFETCH -- requirements
Module: if_stage_prefetch

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC and instruction-memory address.
REQ-002 Parameter DATA_W, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, prefetch queue entries; power of two, at least 2.
REQ-004 Parameter PC_STEP, default 4, PC increment per fetched instruction.
REQ-005 Parameter RESET_PC, default 0, fetch address after reset.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 freeze  input  1  decode stall; holds the queue head.
REQ-009 Branch_token  input  1  branch taken; flush and redirect.
REQ-010 BranchAddr  input  ADDR_W  redirect target.
REQ-011 imem_addr  output  ADDR_W  fetch address, equals current fetch PC.
REQ-012 imem_ready  input  1  memory can return imem_rdata this cycle.
REQ-013 imem_rdata  input  DATA_W  instruction at imem_addr, same-cycle (combinational) return.
REQ-014 out_valid  output  1  queue head valid.
REQ-015 PC  output  ADDR_W  head entry's fetch address plus PC_STEP.
REQ-016 Instruction  output  DATA_W  head entry instruction.
REQ-017 count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-018 fetch_pc register SHALL drive imem_addr directly.
REQ-019 pop SHALL equal out_valid AND NOT freeze AND NOT Branch_token.
REQ-020 push SHALL equal imem_ready AND NOT Branch_token AND (count<DEPTH OR pop).
REQ-021 On push, entry {fetch_pc+PC_STEP, imem_rdata} SHALL be written at tail and fetch_pc SHALL advance by PC_STEP.
REQ-022 fetch_pc arithmetic SHALL wrap modulo 2^ADDR_W; PC output likewise.
REQ-023 Queue pointers SHALL wrap modulo DEPTH; full with simultaneous pop SHALL still accept push, count unchanged.
REQ-024 Empty queue: out_valid=0, PC and Instruction hold last head contents (don't-care for checking); pop impossible.
REQ-025 Outputs out_valid, PC, Instruction SHALL be combinational from head entry; fetch-to-output latency one cycle minimum.
REQ-026 Branch_token=1 SHALL, next cycle, empty the queue (count=0), set fetch_pc=BranchAddr; no push or pop in that cycle.
REQ-027 freeze=1 SHALL hold head and keep fetching until full; with freeze and full, fetch_pc SHALL hold.
REQ-028 Branch_token SHALL take priority over freeze.
REQ-029 imem_ready=0 SHALL suppress push; pop continues normally.
REQ-030 count SHALL change by +1 (push only), -1 (pop only), 0 (both/neither).

Reset
REQ-031 rst=1 SHALL set fetch_pc=RESET_PC, count=0, pointers=0, out_valid=0; rst overrides Branch_token, freeze, imem_ready.
REQ-032 rst asserted mid-operation SHALL discard all queued entries in the same edge.

Configuration
REQ-033 Macro IF_PERF_CNT_EN defined: adds outputs flush_cnt (32 bits, increments per Branch_token cycle) and stall_cnt (32 bits, increments per cycle with out_valid AND freeze), both reset to 0, wrapping.
REQ-034 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-035 Shared package if_pkg SHALL hold default parameter constants and the queue entry typedef {pc, instr}.
REQ-036 Queue storage and pointers SHALL be one sub-module if_fifo (parametrised width/depth, push/pop/flush, count); PC logic in top.

Verification
REQ-037 Reset then imem_ready=1, freeze=0: out_valid rises one cycle after reset release, PC=4, 8, 12 on consecutive cycles, count stays 1.
REQ-038 freeze=1 for 6 cycles, DEPTH=4: count reaches 4, imem_addr holds 16, head PC=4 stable; release drains 4,8,12,16 in order.
REQ-039 Branch_token with BranchAddr=0x100 while count=3: next cycle count=0, imem_addr=0x100; following cycle head PC=0x104.
REQ-040 Branch_token and freeze together with full queue: flush wins, count=0 next cycle.
REQ-041 RESET_PC=0xFFFFFFFC, run 2 fetches: PC outputs 0x0 then 0x4 (wrap).
REQ-042 With IF_PERF_CNT_EN: 3 branch pulses and 5 frozen-valid cycles give flush_cnt=3, stall_cnt=5; rst clears both.
